// File: rtl/lut_pkg.sv
// Shared constants, grant encoding and width helper for the 16x4 lookup-table port controller.
package lut_pkg;

  localparam int LUT_AW        = 4;
  localparam int LUT_DW        = 4;
  localparam int LUT_RSP_DEPTH = 2;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

  // Bits needed to count 0..depth entries.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lut_rsp_fifo.sv
// Response FIFO holding {addr, data} pairs returned by the lookup table, oldest entry on dout.
module lut_rsp_fifo
  import lut_pkg::*;
#(
  parameter int W     = LUT_AW + LUT_DW,
  parameter int DEPTH = LUT_RSP_DEPTH,
  localparam int OW   = occ_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [OW-1:0] occ,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: storage is not reset; occ/empty qualify every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (occ == '0);

endmodule

// File: rtl/lut_port_ctrl.sv
// Merges write and read request streams onto the lookup table's WE/RE port pair, one command per cycle.
// Define LUT_RR_ARB_EN for round-robin conflict arbitration; otherwise writes have fixed priority.
module lut_port_ctrl
  import lut_pkg::*;
#(
  parameter int AW        = LUT_AW,
  parameter int DW        = LUT_DW,
  parameter int RSP_DEPTH = LUT_RSP_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_data,
  output logic          lut_WE,
  output logic          lut_RE,
  output logic [AW-1:0] lut_addrW,
  output logic [AW-1:0] lut_addrR,
  output logic [DW-1:0] lut_dataIn,
  input  logic [DW-1:0] lut_dataOut
);

  localparam int OW = occ_width(RSP_DEPTH);
  localparam int CW = OW + 1;

  logic             run;
  logic             rd_pend;
  logic [AW-1:0]    pend_addr;
  logic [OW-1:0]    occ;
  logic             empty;
  logic             pop;
  logic [CW-1:0]    credit_used;
  logic             rd_ok;
  logic             conflict;
  logic             grant_w;
  logic             grant_r;
  logic [AW+DW-1:0] dout;

  // A read may issue only if its response is guaranteed a FIFO slot, counting the one in flight.
  assign pop         = rsp_valid & rsp_ready;
  assign credit_used = CW'(occ) + CW'(rd_pend) - CW'(pop);
  assign rd_ok       = credit_used < CW'(RSP_DEPTH);
  assign conflict    = run & wr_valid & rd_valid & rd_ok;

`ifdef LUT_RR_ARB_EN
  grant_e last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_grant <= GNT_RD;
    else if (conflict) last_grant <= grant_w ? GNT_WR : GNT_RD;
  end
`endif

  // NOTE: both grants get a default first so every path assigns them and no latch is inferred.
  always_comb begin
    grant_w = 1'b0;
    grant_r = 1'b0;
    if (conflict) begin
`ifdef LUT_RR_ARB_EN
      grant_w = (last_grant == GNT_RD);
      grant_r = (last_grant == GNT_WR);
`else
      grant_w = 1'b1;
`endif
    end else if (run && wr_valid) begin
      grant_w = 1'b1;
    end else if (run && rd_valid && rd_ok) begin
      grant_r = 1'b1;
    end
  end

  assign wr_ready   = wr_valid & grant_w;
  assign rd_ready   = rd_valid & grant_r;
  assign lut_WE     = wr_ready;
  assign lut_RE     = rd_ready;
  assign lut_addrW  = wr_addr;
  assign lut_addrR  = rd_addr;
  assign lut_dataIn = wr_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      rd_pend   <= 1'b0;
      pend_addr <= '0;
    end else begin
      run     <= 1'b1;
      rd_pend <= lut_RE;
      if (lut_RE) pend_addr <= rd_addr;
    end
  end

  // The table's registered data is valid the cycle after the read, alongside pend_addr.
  lut_rsp_fifo #(
    .W     (AW + DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_pend),
    .pop   (pop),
    .din   ({pend_addr, lut_dataOut}),
    .dout  (dout),
    .occ   (occ),
    .empty (empty)
  );

  assign rsp_valid            = ~empty;
  assign {rsp_addr, rsp_data} = dout;

endmodule

// File: tb/tb_lut_port_ctrl.sv
// Directed bench for lut_port_ctrl with a behavioural 16x4 table (registered read) attached to its port.
module tb_lut_port_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, rd_valid, rsp_ready;
  logic [3:0] wr_addr, wr_data, rd_addr;
  logic       wr_ready, rd_ready, rsp_valid;
  logic [3:0] rsp_addr, rsp_data;
  logic       lut_WE, lut_RE;
  logic [3:0] lut_addrW, lut_addrR, lut_dataIn;
  logic [3:0] lut_dataOut = 4'd0;

  int checks   = 0;
  int failures = 0;

  logic [3:0] table_mem [16];

  always #5 clk = ~clk;

  lut_port_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_addr    (rsp_addr),
    .rsp_data    (rsp_data),
    .lut_WE      (lut_WE),
    .lut_RE      (lut_RE),
    .lut_addrW   (lut_addrW),
    .lut_addrR   (lut_addrR),
    .lut_dataIn  (lut_dataIn),
    .lut_dataOut (lut_dataOut)
  );

  // Table model: unaffected by rst_n, write and registered read on posedge.
  always @(posedge clk) begin
    if (lut_WE) table_mem[lut_addrW] <= lut_dataIn;
    if (lut_RE) lut_dataOut <= table_mem[lut_addrR];
  end

  // Drive one cycle's inputs at the falling edge, then settle before anything is sampled.
  task automatic drive(input logic wv, input logic [3:0] wa, input logic [3:0] wd,
                       input logic rv, input logic [3:0] ra, input logic rr);
    @(negedge clk);
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    rd_valid  = rv;
    rd_addr   = ra;
    rsp_ready = rr;
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 4'd3, 4'd3, 1'b1, 4'd3, 1'b1);
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready got=%b exp=0", wr_ready); end
    checks++; if (rd_ready !== 1'b0) begin failures++; $display("FAIL rst_rd_ready got=%b exp=0", rd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    // Release with both requests pending: run is still 0 for this cycle.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (lut_WE !== 1'b0 || lut_RE !== 1'b0) begin failures++; $display("FAIL rel_no_grant got=%b%b exp=00", lut_WE, lut_RE); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rel_rsp_valid got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_read;
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 1'b1);
    checks++; if (rd_ready !== 1'b1 || lut_RE !== 1'b1) begin failures++; $display("FAIL rd_accept got=%b%b exp=11", rd_ready, lut_RE); end
    checks++; if (lut_addrR !== 4'd5) begin failures++; $display("FAIL rd_lut_addr got=%0d exp=5", lut_addrR); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_lat_n1 got=%b exp=0", rsp_valid); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 4'd5 || rsp_data !== 4'd8) begin
      failures++; $display("FAIL rd_rsp got=%b/%0d/%0d exp=1/5/8", rsp_valid, rsp_addr, rsp_data); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_drained got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_write_then_read;
    drive(1'b1, 4'd15, 4'd3, 1'b0, 4'd0, 1'b1);
    checks++; if (wr_ready !== 1'b1 || lut_WE !== 1'b1 || lut_RE !== 1'b0) begin
      failures++; $display("FAIL wr_accept got=%b%b%b exp=110", wr_ready, lut_WE, lut_RE); end
    checks++; if (lut_addrW !== 4'd15 || lut_dataIn !== 4'd3) begin
      failures++; $display("FAIL wr_lut_bus got=%0d/%0d exp=15/3", lut_addrW, lut_dataIn); end
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 1'b1);
    checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL wr_rd_accept got=%b exp=1", rd_ready); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 4'd15 || rsp_data !== 4'd3) begin
      failures++; $display("FAIL wr_visible got=%b/%0d/%0d exp=1/15/3", rsp_valid, rsp_addr, rsp_data); end
    drive(1'b1, 4'd15, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL wr_restore got=%b exp=1", wr_ready); end
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 1'b1);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'd0) begin
      failures++; $display("FAIL wr_restored got=%b/%0d exp=1/0", rsp_valid, rsp_data); end
  endtask

  task automatic test_arbitration;
`ifdef LUT_RR_ARB_EN
    logic [3:0] exp_w = 4'b0101;  // bit i = expected wr_ready in conflict cycle i
`else
    logic [3:0] exp_w = 4'b1111;
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd0, 4'd7, 1'b1, 4'd0, 1'b1);
      checks++; if (wr_ready !== exp_w[i] || rd_ready !== ~exp_w[i]) begin
        failures++; $display("FAIL arb_cycle%0d got=w%b r%b exp=w%b r%b", i, wr_ready, rd_ready, exp_w[i], ~exp_w[i]); end
    end
`ifdef LUT_RR_ARB_EN
    // Reads went out in conflict cycles 1 and 3, both after a write of 7 to addr 0.
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL arb_gap got=%b exp=0", rsp_valid); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 4'd0 || rsp_data !== 4'd7) begin
      failures++; $display("FAIL arb_rsp2 got=%b/%0d/%0d exp=1/0/7", rsp_valid, rsp_addr, rsp_data); end
`else
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL arb_starved_rsp got=%b exp=0", rsp_valid); end
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1);
    checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL arb_unstarve got=%b exp=1", rd_ready); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 4'd0 || rsp_data !== 4'd7) begin
      failures++; $display("FAIL arb_rsp got=%b/%0d/%0d exp=1/0/7", rsp_valid, rsp_addr, rsp_data); end
`endif
    drive(1'b1, 4'd0, 4'd10, 1'b0, 4'd0, 1'b1);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL arb_restore got=%b exp=1", wr_ready); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL arb_drained got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_backpressure;
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0);
    checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL bp_rd0 got=%b exp=1", rd_ready); end
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 1'b0);
    checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL bp_rd5 got=%b exp=1", rd_ready); end
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 1'b0);
    checks++; if (rd_ready !== 1'b0) begin failures++; $display("FAIL bp_credit_a got=%b exp=0", rd_ready); end
    checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 4'd0 || rsp_data !== 4'd10) begin
      failures++; $display("FAIL bp_head got=%b/%0d/%0d exp=1/0/10", rsp_valid, rsp_addr, rsp_data); end
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 1'b0);
    checks++; if (rd_ready !== 1'b0) begin failures++; $display("FAIL bp_credit_b got=%b exp=0", rd_ready); end
    checks++; if (rsp_addr !== 4'd0 || rsp_data !== 4'd10) begin
      failures++; $display("FAIL bp_hold got=%0d/%0d exp=0/10", rsp_addr, rsp_data); end
    // Full FIFO popping this cycle frees the credit for addr 15 in the same cycle.
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 1'b1);
    checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL bp_release_rd got=%b exp=1", rd_ready); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'd10) begin
      failures++; $display("FAIL bp_rsp0 got=%b/%0d exp=1/10", rsp_valid, rsp_data); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 4'd5 || rsp_data !== 4'd8) begin
      failures++; $display("FAIL bp_rsp1 got=%b/%0d/%0d exp=1/5/8", rsp_valid, rsp_addr, rsp_data); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 4'd15 || rsp_data !== 4'd0) begin
      failures++; $display("FAIL bp_rsp2 got=%b/%0d/%0d exp=1/15/0", rsp_valid, rsp_addr, rsp_data); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_data [8] = '{4'd10, 4'd14, 4'd13, 4'd12, 4'd11, 4'd8, 4'd9, 4'd8};
    for (int k = 0; k < 11; k++) begin
      drive(1'b0, 4'd0, 4'd0, (k < 8), 4'(k), 1'b1);
      if (k < 8) begin
        checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL b2b_rd%0d got=%b exp=1", k, rd_ready); end
      end
      if (k >= 2 && k < 10) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 4'(k - 2) || rsp_data !== exp_data[k-2]) begin
          failures++; $display("FAIL b2b_rsp%0d got=%b/%0d/%0d exp=1/%0d/%0d", k - 2, rsp_valid, rsp_addr, rsp_data, k - 2, exp_data[k-2]); end
      end else if (k == 10) begin
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", rsp_valid); end
      end
    end
  endtask

  task automatic test_reset_mid_op;
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 1'b0);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b exp=1", rsp_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_async got=%b exp=0", rsp_valid); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    @(negedge clk);
    rst_n   = 1'b1;
    rd_valid = 1'b1;
    rd_addr  = 4'd0;
    #1;
    checks++; if (rd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL mid_first got=%b%b exp=00", rd_ready, rsp_valid); end
    drive(1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1);
    checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL mid_rd got=%b exp=1", rd_ready); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_no_stale got=%b exp=0", rsp_valid); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 4'd0 || rsp_data !== 4'd10) begin
      failures++; $display("FAIL mid_rsp got=%b/%0d/%0d exp=1/0/10", rsp_valid, rsp_addr, rsp_data); end
  endtask

  initial begin
    // Power-up table: mem[0]=10, mem[5]=8, mem[15]=0, others 15-i.
    for (int i = 0; i < 16; i++) table_mem[i] = 4'(15 - i);
    table_mem[0] = 4'd10;
    table_mem[5] = 4'd8;
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    rd_valid  = 1'b0;
    rsp_ready = 1'b1;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr   = '0;
    test_reset();
    test_read();
    test_write_then_read();
    test_arbitration();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
